// File: rtl/regfile_mp_scoreboard.sv
// Multi-port register file with write-to-read bypass, optional zero register and a
// per-register pending-write scoreboard; a clear pass after reset zeroes the array.
module regfile_mp_scoreboard #(
   parameter int DW       = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int NUM_WR   = 1,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 ready_o,
   input  logic [NUM_RD*AW-1:0] rd_addr_i,
   output logic [NUM_RD*DW-1:0] rd_data_o,
   output logic [NUM_RD-1:0]    busy_o,
   input  logic [NUM_WR-1:0]    wr_en_i,
   input  logic [NUM_WR*AW-1:0] wr_addr_i,
   input  logic [NUM_WR*DW-1:0] wr_data_i,
   input  logic                 claim_en_i,
   input  logic [AW-1:0]        claim_addr_i
);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t           state;
   state_t           state_nxt;
   logic             run;
   logic [AW-1:0]    clr_cnt;
   logic [DW-1:0]    regs [DEPTH];
   logic [DEPTH-1:0] busy;

   logic [AW-1:0]    rd_addr [NUM_RD];
   logic [DW-1:0]    rd_val  [NUM_RD];
   logic             rd_busy [NUM_RD];
   logic [AW-1:0]    wr_addr [NUM_WR];
   logic [DW-1:0]    wr_data [NUM_WR];
   logic             wr_ok   [NUM_WR];
   logic             claim_ok;

   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      assign rd_addr[r]            = rd_addr_i[r*AW +: AW];
      assign rd_data_o[r*DW +: DW] = rd_val[r];
      assign busy_o[r]             = rd_busy[r];
   end

   // A write to the hardwired zero register is dropped before it reaches the array.
   for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
      assign wr_addr[w] = wr_addr_i[w*AW +: AW];
      assign wr_data[w] = wr_data_i[w*DW +: DW];
      assign wr_ok[w]   = wr_en_i[w] && !(ZERO_REG && (wr_addr[w] == '0));
   end

   assign claim_ok = claim_en_i && !(ZERO_REG && (claim_addr_i == '0));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_cnt <= clr_cnt + AW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_cnt == AW'(DEPTH-1)) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   always_comb begin
      run     = (state == RUN);
      ready_o = run;
   end

   // Later write ports are applied last, so the highest index wins a collision.
   always_ff @(posedge clk_i) begin
      if (state == CLEAR) begin
         regs[clr_cnt] <= '0;
      end else begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) regs[wr_addr[w]] <= wr_data[w];
         end
      end
   end

   // Claims are applied after write clears so a fresh producer keeps the bit set.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy <= '0;
      end else if (run) begin
         for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en_i[w]) busy[wr_addr[w]] <= 1'b0;
         end
         if (claim_ok) busy[claim_addr_i] <= 1'b1;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         rd_val[r]  = regs[rd_addr[r]];
         rd_busy[r] = busy[rd_addr[r]];
         if (BYPASS) begin
            for (int w = 0; w < NUM_WR; w++) begin
               if (wr_en_i[w] && (wr_addr[w] == rd_addr[r])) begin
                  rd_val[r]  = wr_data[w];
                  rd_busy[r] = 1'b0;
               end
            end
         end
         if ((ZERO_REG && (rd_addr[r] == '0)) || !run) begin
            rd_val[r]  = '0;
            rd_busy[r] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Scoreboard bench: drives a bypassing and a non-bypassing register file in lockstep
// and compares both against a reference model of the register array and busy bits.
module tb_regfile_mp_scoreboard;

   localparam int DW    = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   typedef struct packed {
      logic        ready;
      logic [63:0] data_b;
      logic [1:0]  busy_b;
      logic [63:0] data_n;
      logic [1:0]  busy_n;
   } expect_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  rd_addr = '0;
   logic [1:0]  wr_en = '0;
   logic [9:0]  wr_addr = '0;
   logic [63:0] wr_data = '0;
   logic        claim_en = 1'b0;
   logic [4:0]  claim_addr = '0;

   logic        ready_b, ready_n;
   logic [63:0] data_b, data_n;
   logic [1:0]  busy_b, busy_n;

   logic [31:0] model_regs [DEPTH];
   logic        model_busy [DEPTH];
   logic        model_ready = 1'b0;
   expect_t     sb_q [$];
   int          errors = 0;
   int          checks = 0;
   int          cycles;

   regfile_mp_scoreboard #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(2), .NUM_WR(2),
                           .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_byp (
      .clk_i(clk), .rst_i(rst), .ready_o(ready_b),
      .rd_addr_i(rd_addr), .rd_data_o(data_b), .busy_o(busy_b),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .claim_en_i(claim_en), .claim_addr_i(claim_addr)
   );

   regfile_mp_scoreboard #(.DW(DW), .DEPTH(DEPTH), .NUM_RD(2), .NUM_WR(2),
                           .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nob (
      .clk_i(clk), .rst_i(rst), .ready_o(ready_n),
      .rd_addr_i(rd_addr), .rd_data_o(data_n), .busy_o(busy_n),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .claim_en_i(claim_en), .claim_addr_i(claim_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Reference read of one port given the currently driven write inputs.
   function automatic void modelRead(input logic [4:0] a, input bit bypass,
                                     output logic [31:0] d, output logic b);
      d = model_regs[a];
      b = model_busy[a];
      if (bypass) begin
         if (wr_en[0] && wr_addr[4:0] == a) begin d = wr_data[31:0];  b = 1'b0; end
         if (wr_en[1] && wr_addr[9:5] == a) begin d = wr_data[63:32]; b = 1'b0; end
      end
      if (a == 5'd0 || !model_ready) begin d = '0; b = 1'b0; end
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < DEPTH; i++) begin
         model_regs[i] = '0;
         model_busy[i] = 1'b0;
      end
   endfunction

   task automatic applyStimulus(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic ce, input logic [4:0] ca,
                                input logic [4:0] ra0, input logic [4:0] ra1);
      expect_t     e;
      expect_t     got;
      logic [31:0] d;
      logic        b;
      logic [4:0]  ra [2];
      @(posedge clk);
      #1;
      wr_en      = we;
      wr_addr    = {wa1, wa0};
      wr_data    = {wd1, wd0};
      claim_en   = ce;
      claim_addr = ca;
      rd_addr    = {ra1, ra0};
      ra[0] = ra0;
      ra[1] = ra1;
      e.ready = model_ready;
      for (int r = 0; r < 2; r++) begin
         modelRead(ra[r], 1'b1, d, b);
         e.data_b[r*32 +: 32] = d;
         e.busy_b[r]          = b;
         modelRead(ra[r], 1'b0, d, b);
         e.data_n[r*32 +: 32] = d;
         e.busy_n[r]          = b;
      end
      sb_q.push_back(e);
      @(negedge clk);
      got = sb_q.pop_front();
      checkOutput("ready_byp", {63'd0, ready_b}, {63'd0, got.ready});
      checkOutput("ready_nob", {63'd0, ready_n}, {63'd0, got.ready});
      checkOutput("rdata_byp", data_b, got.data_b);
      checkOutput("rdata_nob", data_n, got.data_n);
      checkOutput("busy_byp", {62'd0, busy_b}, {62'd0, got.busy_b});
      checkOutput("busy_nob", {62'd0, busy_n}, {62'd0, got.busy_n});
      if (model_ready) begin
         if (we[0] && wa0 != 0) begin model_regs[wa0] = wd0; end
         if (we[1] && wa1 != 0) begin model_regs[wa1] = wd1; end
         if (we[0]) model_busy[wa0] = 1'b0;
         if (we[1]) model_busy[wa1] = 1'b0;
         if (ce && ca != 0) model_busy[ca] = 1'b1;
      end
   endtask

   // Counts rising edges until both instances report ready, bounded by a cycle budget.
   task automatic waitClear(input string tag);
      cycles = 0;
      do begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == 3) begin
            checkOutput({tag, "_rdata_clear"}, data_b | data_n, 64'd0);
            checkOutput({tag, "_busy_clear"}, {62'd0, busy_b | busy_n}, 64'd0);
         end
         if (cycles == 5) begin
            wr_en    = 2'b00;
            claim_en = 1'b0;
         end
      end while (!(ready_b && ready_n) && cycles < 200);
      checkOutput({tag, "_clear_cycles"}, 64'(cycles), 64'(DEPTH));
      modelReset();
      model_ready = 1'b1;
   endtask

   initial begin
      modelReset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("ready_in_reset", {62'd0, ready_b, ready_n}, 64'd0);
      // Writes and claims during the clear pass must have no effect.
      wr_en      = 2'b01;
      wr_addr    = {5'd0, 5'd3};
      wr_data    = {32'd0, 32'h0000FFFF};
      claim_en   = 1'b1;
      claim_addr = 5'd3;
      rd_addr    = {5'd4, 5'd3};
      rst        = 1'b0;
      waitClear("rst1");

      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd31);
      applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5);
      applyStimulus(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 5'd5);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd0);
      repeat (3) applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
      applyStimulus(2'b01, 5'd7, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd1);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
      applyStimulus(2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 1'b0, 5'd0, 5'd9, 5'd9);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd5);
      applyStimulus(2'b01, 5'd9, 32'h33, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd31);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd31);
      applyStimulus(2'b10, 5'd0, 32'h0, 5'd31, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd31, 5'd30);

      for (int i = 0; i < 40; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom(),
                       5'($urandom_range(0, 31)), $urandom(), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                       5'($urandom_range(0, 31)));
      end

      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd12, 5'd9);
      applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd9);

      // Asynchronous reset in the middle of a cycle with busy bits set.
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("ready_async_rst", {62'd0, ready_b, ready_n}, 64'd0);
      checkOutput("busy_async_rst", {60'd0, busy_b, busy_n}, 64'd0);
      model_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      waitClear("rst2");
      for (int a = 0; a < DEPTH; a += 2) begin
         applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(a), 5'(a + 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
